register_file: RTL

//   Responder side of decode's operand-fetch interface. Holds the 32 integer (greg) and 32 FP (freg)

---
 rtl/cpu_pkg.sv | 10 +
 rtl/register_file_if.sv | 37 +++
 rtl/register_file_regbank.sv | 58 +++++
 rtl/register_file.sv | 55 +++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: writeback/reservation selector codes and register geometry.
package cpu_pkg;
  localparam int WIDTH     = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_GREG = 2'b01;
  localparam logic [1:0] WSEL_FREG = 2'b10;
endpackage

// File: rtl/register_file_if.sv
// Operand-fetch / writeback bus between decode+writeback (master) and the register file (slave).
interface register_file_if;
  import cpu_pkg::*;

  logic [REG_IDX_W-1:0] rgreg1, rgreg2, rfreg1, rfreg2;
  logic [WIDTH-1:0]     greg_out1, greg_out2, freg_out1, freg_out2;
  logic                 gbusy1, gbusy2, fbusy1, fbusy2;

  logic                 resv_enable;
  logic [1:0]           resv_selector;
  logic [REG_IDX_W-1:0] resv_reg;

  // wenable is a single-cycle request; wdone pulses once the cycle after, no backpressure.
  logic                 wenable;
  logic [1:0]           wselector;
  logic [REG_IDX_W-1:0] wreg;
  logic [WIDTH-1:0]     wdata;
  logic                 wdone;

  modport master (
    output rgreg1, rgreg2, rfreg1, rfreg2,
    input  greg_out1, greg_out2, freg_out1, freg_out2,
    input  gbusy1, gbusy2, fbusy1, fbusy2,
    output resv_enable, resv_selector, resv_reg,
    output wenable, wselector, wreg, wdata,
    input  wdone
  );

  modport slave (
    input  rgreg1, rgreg2, rfreg1, rfreg2,
    output greg_out1, greg_out2, freg_out1, freg_out2,
    output gbusy1, gbusy2, fbusy1, fbusy2,
    input  resv_enable, resv_selector, resv_reg,
    input  wenable, wselector, wreg, wdata,
    output wdone
  );
endinterface

// File: rtl/register_file_regbank.sv
// One 32-entry register bank: two combinational read ports with write-through, one write
// port, and a pending bit per register for RAW hazard detection.
module regbank
  import cpu_pkg::*;
#(
  parameter bit HARDZERO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [WIDTH-1:0]     rdata1,
  output logic [WIDTH-1:0]     rdata2,
  output logic                 busy1,
  output logic                 busy2,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 resv,
  input  logic [REG_IDX_W-1:0] resv_addr
);
  logic [WIDTH-1:0] mem [NREG];
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_next;
  logic             wr_ok, rv_ok;
  logic             hit1, hit2, remark1, remark2;

  // With HARDZERO, register 0 swallows writes and reservations, so it stays 0 and never busy.
  assign wr_ok = we   && !(HARDZERO && (waddr == '0));
  assign rv_ok = resv && !(HARDZERO && (resv_addr == '0));

  assign hit1    = wr_ok && (waddr == raddr1);
  assign hit2    = wr_ok && (waddr == raddr2);
  assign remark1 = rv_ok && (resv_addr == raddr1);
  assign remark2 = rv_ok && (resv_addr == raddr2);

  assign rdata1 = hit1 ? wdata : mem[raddr1];
  assign rdata2 = hit2 ? wdata : mem[raddr2];
  assign busy1  = pending[raddr1] && !(hit1 && !remark1);
  assign busy2  = pending[raddr2] && !(hit2 && !remark2);

  // Reserve is applied after the release so a new producer keeps ownership.
  always_comb begin
    pending_next = pending;
    if (wr_ok) pending_next[waddr] = 1'b0;
    if (rv_ok) pending_next[resv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_ok) mem[waddr] <= wdata;
      pending <= pending_next;
    end
  end
endmodule

// File: rtl/register_file.sv
// Integer and FP architectural register files; decodes the write/reserve selectors and
// produces the wdone acknowledge pulse.
module register_file
  import cpu_pkg::*;
(
  input logic            clk,
  input logic            rst,
  register_file_if.slave rf
);
  logic g_we, f_we, g_rv, f_rv, w_accept;

  assign g_we = rf.wenable && (rf.wselector == WSEL_GREG);
  assign f_we = rf.wenable && (rf.wselector == WSEL_FREG);
  assign g_rv = rf.resv_enable && (rf.resv_selector == WSEL_GREG);
  assign f_rv = rf.resv_enable && (rf.resv_selector == WSEL_FREG);
  // A write to greg r0 is discarded by the bank but still acknowledged.
  assign w_accept = g_we || f_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf.wdone <= 1'b0;
    else     rf.wdone <= w_accept;
  end

  regbank #(.HARDZERO(1'b1)) u_greg (
    .clk       (clk),
    .rst       (rst),
    .raddr1    (rf.rgreg1),
    .raddr2    (rf.rgreg2),
    .rdata1    (rf.greg_out1),
    .rdata2    (rf.greg_out2),
    .busy1     (rf.gbusy1),
    .busy2     (rf.gbusy2),
    .we        (g_we),
    .waddr     (rf.wreg),
    .wdata     (rf.wdata),
    .resv      (g_rv),
    .resv_addr (rf.resv_reg)
  );

  regbank #(.HARDZERO(1'b0)) u_freg (
    .clk       (clk),
    .rst       (rst),
    .raddr1    (rf.rfreg1),
    .raddr2    (rf.rfreg2),
    .rdata1    (rf.freg_out1),
    .rdata2    (rf.freg_out2),
    .busy1     (rf.fbusy1),
    .busy2     (rf.fbusy2),
    .we        (f_we),
    .waddr     (rf.wreg),
    .wdata     (rf.wdata),
    .resv      (f_rv),
    .resv_addr (rf.resv_reg)
  );
endmodule
